// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM of the multi-cycle RV32I core.
// It decodes the IR opcode and drives every datapath enable and mux select.
// It also keeps a retired-instruction counter and a sticky illegal-instruction flag.
//
// Handshake: imem_read / mem_read / mem_write are requests that are held high
// every cycle until the matching *_ready is seen high, including that cycle.
// The FSM advances only on the cycle where request && ready. A reset abandons
// any outstanding request at once, because all outputs are forced low while RST is high.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      instr,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             imem_read,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd15
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Mux select encodings.
    localparam logic [1:0] A_PC     = 2'b00;
    localparam logic [1:0] A_RS1    = 2'b01;
    localparam logic [1:0] A_OLD_PC = 2'b10;
    localparam logic [1:0] B_RS2    = 2'b00;
    localparam logic [1:0] B_IMM    = 2'b01;
    localparam logic [1:0] B_FOUR   = 2'b10;
    localparam logic [1:0] OP_FUNCT_R = 2'b00;
    localparam logic [1:0] OP_FUNCT_I = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_SUB   = 2'b11;
    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_PC    = 2'b10;
    localparam logic [1:0] WB_IMM   = 2'b11;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;
    logic [6:0]       opcode;

    // Only the opcode field is decoded here; the rest of the IR belongs to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[31:7];
    assign opcode = instr[6:0];

    // State, retired-instruction counter and sticky trap flag registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state decode, counter increment on instruction completion, trap latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (imem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:      state_d = S_EXEC_R;
                    OP_I:      state_d = S_EXEC_I;
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    OP_LUI:    state_d = S_LUI;
                    OP_AUIPC:  state_d = S_WB_ALU;
                    default:   state_d = S_TRAP;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_ALU;
            S_EXEC_I:   state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (dmem_ready) state_d = S_WB_MEM;
            S_MEM_WR:   if (dmem_ready) state_d = S_FETCH;
            S_WB_ALU:   state_d = S_FETCH;
            S_WB_MEM:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_FETCH;
            S_JALR:     state_d = S_FETCH;
            S_LUI:      state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase

        // An instruction retires whenever control returns to FETCH from elsewhere.
        instret_d = instret_q;
        if (state_d == S_FETCH && state_q != S_FETCH) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        // Flag becomes visible in the same cycle the FSM sits in TRAP.
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    // Moore-style datapath controls; everything is held at zero during reset.
    always_comb begin
        imem_read = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        alu_src_a = A_PC;
        alu_src_b = B_RS2;
        alu_op    = OP_FUNCT_R;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        if (!RST) begin
            case (state_q)
                S_FETCH: begin
                    imem_read = 1'b1;
                    if (imem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        alu_src_a = A_PC;
                        alu_src_b = B_FOUR;
                        alu_op    = OP_ADD;
                        pc_src    = 1'b0;
                    end
                end
                S_DECODE: begin
                    alu_src_a = A_OLD_PC;
                    alu_src_b = B_IMM;
                    alu_op    = OP_ADD;
                end
                S_EXEC_R: begin
                    alu_src_a = A_RS1;
                    alu_src_b = B_RS2;
                    alu_op    = OP_FUNCT_R;
                end
                S_EXEC_I: begin
                    alu_src_a = A_RS1;
                    alu_src_b = B_IMM;
                    alu_op    = OP_FUNCT_I;
                end
                S_MEM_ADDR: begin
                    alu_src_a = A_RS1;
                    alu_src_b = B_IMM;
                    alu_op    = OP_ADD;
                end
                S_MEM_RD: mem_read  = 1'b1;
                S_MEM_WR: mem_write = 1'b1;
                S_WB_ALU: begin
                    reg_write = 1'b1;
                    wb_sel    = WB_ALU;
                end
                S_WB_MEM: begin
                    reg_write = 1'b1;
                    wb_sel    = WB_MEM;
                end
                S_LUI: begin
                    reg_write = 1'b1;
                    wb_sel    = WB_IMM;
                end
                S_BRANCH: begin
                    alu_src_a = A_RS1;
                    alu_src_b = B_RS2;
                    alu_op    = OP_SUB;
                    if (branch_taken) begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end
                end
                S_JAL: begin
                    // PC already holds old_pc+4, so the link value comes straight from PC.
                    reg_write = 1'b1;
                    wb_sel    = WB_PC;
                    pc_write  = 1'b1;
                    pc_src    = 1'b1;
                end
                S_JALR: begin
                    // Target computed this cycle; the datapath clears bit 0.
                    alu_src_a = A_RS1;
                    alu_src_b = B_IMM;
                    alu_op    = OP_ADD;
                    pc_write  = 1'b1;
                    pc_src    = 1'b0;
                    reg_write = 1'b1;
                    wb_sel    = WB_PC;
                end
                default: ;
            endcase
        end
    end

    // Debug and status views, forced low during reset like every other output.
    always_comb begin
        state   = RST ? 4'd0 : state_q;
        instret = RST ? '0 : instret_q;
        illegal = RST ? 1'b0 : illegal_q;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main sequencing FSM for the multi-cycle RV32I core. It decodes the latched instruction opcode and drives every datapath enable and mux select: IR/PC write, ALU operand selects, ALUOp to the ALU control decoder, register write-back, and IMEM/DMEM requests. IMEM and DMEM use a ready handshake, so wait states are supported. It also keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
CLK  in  1  core clock
RST  in  1  synchronous, active-high reset
instr  in  32  IR contents; only [6:0] are decoded here
imem_ready  in  1  IMEM read data valid this cycle
dmem_ready  in  1  DMEM read data valid / write accepted this cycle
branch_taken  in  1  datapath comparator result for the current branch funct3
imem_read  out  1  IMEM request
ir_write  out  1  latch IR and old_pc
pc_write  out  1  PC update enable
pc_src  out  1  0: combinational ALU result, 1: ALUOut register
alu_src_a  out  2  00 PC, 01 rs1, 10 old_pc
alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
alu_op  out  2  00 R-type funct decode, 01 I-type funct decode, 10 force ADD, 11 force SUB
mem_read  out  1  DMEM read request
mem_write  out  1  DMEM write request
reg_write  out  1  register file write enable
wb_sel  out  2  00 ALUOut, 01 mem data, 10 PC, 11 imm
illegal  out  1  sticky trap flag
state  out  4  current state, for debug
instret  out  CNT_W  retired-instruction count

Behaviour:
- Outputs are Moore-style. They decode from state, plus the ready and branch_taken inputs where noted. Every enable and select defaults to 0.
- While RST=1, all outputs are forced to 0 combinationally. On the next edge: state<=FETCH, instret<=0, illegal<=0.
- A reset asserted mid-operation abandons the transaction immediately. No partial writes occur.
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JAL=10, JALR=11, LUI=12, TRAP=15.
- FETCH:
  - imem_read=1; stay in FETCH while imem_ready=0.
  - When imem_ready=1: ir_write=1, pc_write=1, a=PC, b=4, alu_op=10, pc_src=0, so PC<=PC+4. Next state is DECODE.
- DECODE: a=old_pc, b=imm, alu_op=10, so ALUOut<=branch/JAL/AUIPC target. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 and 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → WB_ALU
  - anything else → TRAP
- EXEC_R: a=rs1, b=rs2, alu_op=00 → WB_ALU.
- EXEC_I: a=rs1, b=imm, alu_op=01 → WB_ALU.
- MEM_ADDR: a=rs1, b=imm, alu_op=10 → MEM_RD for loads, MEM_WR for stores.
- MEM_RD / MEM_WR:
  - mem_read (or mem_write) is held at 1 every cycle until dmem_ready=1, including the ready cycle.
  - MEM_RD then goes to WB_MEM; MEM_WR then goes to FETCH.
- WB_ALU: reg_write=1, wb_sel=00 → FETCH.
- WB_MEM: reg_write=1, wb_sel=01 → FETCH.
- LUI: reg_write=1, wb_sel=11 → FETCH.
- BRANCH: a=rs1, b=rs2, alu_op=11. If branch_taken=1: pc_write=1, pc_src=1. Always → FETCH.
- JAL:
  - reg_write=1, wb_sel=10 (PC already equals old_pc+4), pc_write=1, pc_src=1 → FETCH.
  - The regfile samples the pre-edge PC value.
- JALR: a=rs1, b=imm, alu_op=10, pc_write=1, pc_src=0 (datapath clears bit 0), reg_write=1, wb_sel=10 → FETCH.
- TRAP: illegal<=1 and stays set. All enables are 0. TRAP is left only via RST.
- instret:
  - Increments by 1 on every transition into FETCH from any state other than FETCH, i.e. on each completed instruction.
  - Wraps from 2^CNT_W-1 to 0. TRAP does not count.
- x0 write suppression is the register file's job, not this block's.
- Latency with zero memory wait:
  - 3 cycles: BRANCH, JAL, JALR, LUI, AUIPC
  - 4 cycles: R, I, store
  - 5 cycles: load
- Each ready wait cycle adds one cycle.

Test Plan:
- RST held 2 cycles, then released, imem_ready=1, instr=0x002081B3 (add) → state 0,1,2,7,0. reg_write=1 only in cycle 4 with wb_sel=00, alu_op=00 in EXEC_R. instret 0→1.
- instr=0x0000A103 (lw), dmem_ready low for 3 cycles → mem_read=1 for exactly 4 consecutive cycles, then WB_MEM with wb_sel=01, reg_write=1. instret increments once.
- instr=0x00208463 (beq), branch_taken=1 then repeated with 0 → pc_write=1 with pc_src=1 in the BRANCH cycle only when taken. Both cases return to FETCH after 3 cycles.
- instr=0x0080006F (jal) → JAL cycle asserts reg_write=1, wb_sel=10, pc_write=1, pc_src=1 simultaneously.
- instr=0x00000000 → TRAP (state=15), illegal=1, all enables 0 for 10+ cycles, instret unchanged. RST clears illegal and returns to FETCH.
- RST asserted during MEM_WR wait with dmem_ready=0 → mem_write drops to 0 in the same cycle. state=0 and instret=0 after the edge. No reg_write is seen.
- imem_ready held 0 for 5 cycles → imem_read=1 throughout, ir_write=0 until the ready cycle.
